// File: rtl/imem_fetch_arbiter_pkg.sv
// rtl/imem_fetch_arbiter_pkg.sv - shared state encodings and instruction-memory constants
package cpu_defs;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    EXIT = 2'd2
  } arb_state_t;

  localparam int          IMEM_ADDR_W = 14;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// rtl/imem_fetch_arbiter_if.sv - fetch, loader and RAM port bundle for the imem arbiter
interface imem_fetch_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  logic              ld_start;
  logic              ld_wen;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;

  logic              cpu_hold;
  logic              cpu_restart;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_start, ld_wen, ld_addr, ld_data, ld_done, mem_rdata,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, ld_count,
           cpu_hold, cpu_restart, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_start, ld_wen, ld_addr, ld_data, ld_done, mem_rdata,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, ld_count,
           cpu_hold, cpu_restart, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_fetch_arbiter_ld_counter.sv
// rtl/imem_fetch_arbiter_ld_counter.sv - saturating loader word counter with clear
module imem_ld_counter #(
  parameter int W = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         incr,
  output logic [W-1:0] count
);

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - shares the instruction RAM between CPU fetch and the program loader
module imem_fetch_arbiter
  import cpu_defs::*;
#(
  parameter int                ADDR_W = IMEM_ADDR_W,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSTR)
) (
  input logic                 clock,
  input logic                 reset,
  imem_fetch_arbiter_if.slave bus
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              accept;
  logic              aligned;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              rd_valid;
  logic              rd_err;
  logic [ADDR_W-1:0] fetch_word;
  logic              unused_pc_bits;

  // The PC is a byte address; bits above the RAM window are dropped so fetches wrap.
  assign fetch_word     = bus.fetch_addr[ADDR_W+1:2];
  assign aligned        = (bus.fetch_addr[1:0] == 2'b00);
  assign unused_pc_bits = ^bus.fetch_addr[31:ADDR_W+2];

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = fetch_word;
    unique case (state)
      RUN: begin
        if (bus.ld_start) begin
          state_nxt = LOAD;
          cnt_clr   = 1'b1;
        end else if (bus.fetch_req) begin
          accept     = 1'b1;
          bus.mem_en = aligned;
        end
      end
      LOAD: begin
        if (bus.ld_wen) begin
          bus.mem_en   = 1'b1;
          bus.mem_we   = 1'b1;
          bus.mem_addr = bus.ld_addr;
          cnt_inc      = 1'b1;
        end
        if (bus.ld_done) begin
          state_nxt = EXIT;
        end
      end
      EXIT: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Response flags are registered; the data itself comes straight from the RAM's output register.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= accept;
      rd_err   <= accept && !aligned;
    end
  end

  assign bus.fetch_ready = accept;
  assign bus.fetch_valid = rd_valid;
  assign bus.fetch_err   = rd_err;
  assign bus.fetch_data  = (rd_valid && !rd_err) ? bus.mem_rdata : NOP;
  assign bus.mem_wdata   = bus.ld_data;
  assign bus.cpu_hold    = (state != RUN);
  assign bus.cpu_restart = (state == EXIT);

  imem_ld_counter #(.W(ADDR_W + 1)) u_ld_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .incr  (cnt_inc),
    .count (bus.ld_count)
  );

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - randomized and directed checks of imem_fetch_arbiter against a mode-level model
module tb_imem_fetch_arbiter;
  import cpu_defs::*;

  localparam int AW = 14;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  imem_fetch_arbiter_if #(.ADDR_W(AW), .DATA_W(32)) bus ();
  imem_fetch_arbiter_if #(.ADDR_W(2),  .DATA_W(32)) bus2 ();

  imem_fetch_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  imem_fetch_arbiter #(.ADDR_W(2), .DATA_W(32)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ram2    [0:3];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  always @(negedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata = ram[bus.mem_addr];
    end
    if (bus2.mem_en) begin
      if (bus2.mem_we) ram2[bus2.mem_addr] = bus2.mem_wdata;
      else             bus2.mem_rdata = ram2[bus2.mem_addr];
    end
  end

  int          tests = 0;
  int          fails = 0;
  bit          loading, exiting;
  int          cnt;
  bit          exp_valid, exp_err;
  logic [31:0] exp_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    check_val("cpu_hold", bus.cpu_hold, loading || exiting);
    check_val("cpu_restart", bus.cpu_restart, exiting);
    check_val("ld_count", bus.ld_count, cnt);
    check_val("fetch_valid", bus.fetch_valid, exp_valid);
    check_val("fetch_err", bus.fetch_err, exp_err);
    if (exp_valid) check_val("fetch_data", bus.fetch_data, exp_data);
  endtask

  task automatic step(input bit freq, input logic [31:0] faddr, input bit lst, input bit lwen,
                      input logic [AW-1:0] laddr, input logic [31:0] ldat, input bit ldone);
    bit rd, wr, rd_ok;
    @(posedge clock);
    check_regs();
    #1;
    bus.fetch_req  = freq;
    bus.fetch_addr = faddr;
    bus.ld_start   = lst;
    bus.ld_wen     = lwen;
    bus.ld_addr    = laddr;
    bus.ld_data    = ldat;
    bus.ld_done    = ldone;
    #1;
    rd    = !loading && !exiting && !lst && freq;
    rd_ok = rd && (faddr[1:0] == 2'b00);
    wr    = loading && lwen;
    check_val("fetch_ready", bus.fetch_ready, rd);
    check_val("mem_en", bus.mem_en, rd_ok || wr);
    check_val("mem_we", bus.mem_we, wr);
    if (rd_ok) check_val("mem_addr_rd", bus.mem_addr, faddr[AW+1:2]);
    if (wr) begin
      check_val("mem_addr_wr", bus.mem_addr, laddr);
      check_val("mem_wdata", bus.mem_wdata, ldat);
    end
    exp_valid = rd;
    exp_err   = rd && !rd_ok;
    exp_data  = exp_err ? 32'h0 : ref_mem[faddr[AW+1:2]];
    if (exiting) begin
      exiting = 1'b0;
    end else if (loading) begin
      if (lwen) begin
        ref_mem[laddr] = ldat;
        if (cnt < (1 << (AW + 1)) - 1) cnt++;
      end
      if (ldone) begin
        loading = 1'b0;
        exiting = 1'b1;
      end
    end else if (lst) begin
      loading = 1'b1;
      cnt     = 0;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] fa;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 3; i++) begin
      v = 32'h11 * (i + 1);
      ram[i] = v;
      ref_mem[i] = v;
    end
    {bus.fetch_req, bus.ld_start, bus.ld_wen, bus.ld_done} = '0;
    bus.fetch_addr = '0; bus.ld_addr = '0; bus.ld_data = '0;
    {bus2.fetch_req, bus2.ld_start, bus2.ld_wen, bus2.ld_done} = '0;
    bus2.fetch_addr = '0; bus2.ld_addr = '0; bus2.ld_data = '0;
    loading = 0; exiting = 0; cnt = 0; exp_valid = 0; exp_err = 0; exp_data = 0;

    // reset state
    tick();
    check_val("rst_hold", bus.cpu_hold, 1'b0);
    check_val("rst_restart", bus.cpu_restart, 1'b0);
    check_val("rst_valid", bus.fetch_valid, 1'b0);
    check_val("rst_err", bus.fetch_err, 1'b0);
    check_val("rst_data", bus.fetch_data, 32'h0);
    check_val("rst_count", bus.ld_count, 0);
    reset = 1'b1;

    // back-to-back fetches, then a misaligned one
    step(1, 32'h0, 0, 0, '0, 0, 0);
    step(1, 32'h4, 0, 0, '0, 0, 0);
    step(1, 32'h8, 0, 0, '0, 0, 0);
    step(1, 32'h6, 0, 0, '0, 0, 0);
    idle();

    // read just before load entry, then ld_start beats a fetch, five writes, write+done
    step(1, 32'h20, 0, 0, '0, 0, 0);
    step(1, 32'h10, 1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h0, 1, 1, AW'(i), 32'hA500 + i, 0);
    step(0, 32'h0, 0, 1, AW'(7), 32'h7777, 1);
    idle(); idle(); idle();
    for (int i = 0; i < 8; i++) step(1, 32'(i * 4), 0, 0, '0, 0, 0);
    idle();

    // reset in the middle of a load
    step(0, 32'h0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 1, AW'(100 + i), 32'hC0DE0000 + i, 0);
    @(posedge clock);
    check_regs();
    #1;
    reset = 1'b0;
    {bus.fetch_req, bus.ld_start, bus.ld_wen, bus.ld_done} = '0;
    #1;
    check_val("midload_hold", bus.cpu_hold, 1'b0);
    check_val("midload_count", bus.ld_count, 0);
    check_val("midload_restart", bus.cpu_restart, 1'b0);
    loading = 0; exiting = 0; cnt = 0; exp_valid = 0; exp_err = 0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 32'((100 + i) * 4), 0, 0, '0, 0, 0);
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      fa = $urandom;
      if ($urandom_range(3) != 0) fa[1:0] = 2'b00;
      if ($urandom_range(1) == 1) fa = fa & 32'h0000_00FF;
      step($urandom_range(9) < 7, fa, $urandom_range(19) == 0, 1'($urandom_range(1)),
           AW'($urandom_range(63)), $urandom, $urandom_range(9) == 0);
    end
    step(0, 32'h0, 0, 0, '0, 0, 1);
    idle(); idle(); idle();

    // narrow RAM: count beyond the word range and PC wrap
    bus2.ld_start = 1'b1;
    tick();
    bus2.ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus2.ld_wen  = 1'b1;
      bus2.ld_addr = 2'(i);
      bus2.ld_data = 32'hA0 + i;
      tick();
    end
    bus2.ld_wen = 1'b0;
    check_val("aw2_count", bus2.ld_count, 6);
    check_val("aw2_hold", bus2.cpu_hold, 1'b1);
    bus2.ld_done = 1'b1;
    tick();
    bus2.ld_done = 1'b0;
    check_val("aw2_restart", bus2.cpu_restart, 1'b1);
    tick();
    check_val("aw2_run_hold", bus2.cpu_hold, 1'b0);
    check_val("aw2_run_restart", bus2.cpu_restart, 1'b0);
    bus2.fetch_req  = 1'b1;
    bus2.fetch_addr = 32'h10;
    #1;
    check_val("aw2_mem_en", bus2.mem_en, 1'b1);
    check_val("aw2_mem_addr", bus2.mem_addr, 0);
    tick();
    bus2.fetch_req = 1'b0;
    check_val("aw2_valid", bus2.fetch_valid, 1'b1);
    check_val("aw2_data", bus2.fetch_data, 32'hA4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
